pdm_word_sampler: RTL and testbench

Front-end sampler for the voice-command path. Drives the PDM microphone clock, integrates the microphone's 1-bit stream into `sample_w`-bit amplitude samples (ones-count per window), and packs four samples per 32-bit word for the recording RAM. It sits directly upstream of the voice controller and hands it `ram_data`/`ram_wr` under the controller's `count_en` gating.

---
 rtl/pdm_word_sampler_if.sv | 26 ++
 rtl/pdm_word_sampler.sv | 111 +++++++++++
 tb/tb_pdm_word_sampler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pdm_word_sampler_if.sv
// Interface bundle for pdm_word_sampler: microphone pins, controller gating and RAM write port.
interface pdm_word_sampler_if #(
    parameter int sample_w = 8
);
    logic                    micData;
    logic                    micClk;
    logic                    count_en;
    logic [4*sample_w-1:0]   ram_data;
    logic                    ram_wr;

    modport master (
        input  micData,
        input  count_en,
        output micClk,
        output ram_data,
        output ram_wr
    );

    modport slave (
        output micData,
        output count_en,
        input  micClk,
        input  ram_data,
        input  ram_wr
    );
endinterface

// File: rtl/pdm_word_sampler.sv
// PDM mic clock generator, ones-count integrator and 4-sample word packer.
// Define PDM_SAT_EN to saturate over-range ones counts instead of truncating them.
module pdm_word_sampler #(
    parameter int count_w  = 8,
    parameter int clocks   = 240,
    parameter int sample_w = 8,
    parameter int CLK_DIV  = 42
) (
    input  logic               clk,
    input  logic               rst_n,
    pdm_word_sampler_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int EXT_W = (count_w > sample_w) ? count_w : sample_w;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t                  state, state_nx;
    logic [DIV_W-1:0]        div_cnt;
    logic                    sync1, mic_s;
    logic [count_w-1:0]      win, ones, ones_total;
    logic [1:0]              slot;
    logic [3*sample_w-1:0]   pack;
    logic [EXT_W-1:0]        total_ext;
    logic [sample_w-1:0]     sample;
    logic                    strb, win_last, word_done;

    assign strb       = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign win_last   = (win == count_w'(clocks - 1));
    assign ones_total = ones + count_w'(mic_s);
    assign total_ext  = EXT_W'(ones_total);
    assign word_done  = strb && bus.count_en && win_last && (slot == 2'd3);
    assign bus.ram_wr = (state == EMIT);

`ifdef PDM_SAT_EN
    always_comb begin
        sample = total_ext[sample_w-1:0];
        if (total_ext > EXT_W'({sample_w{1'b1}}))
            sample = '1;
    end
`else
    always_comb begin
        sample = total_ext[sample_w-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.count_en) state_nx = ACCUM;
            ACCUM: begin
                if (!bus.count_en)
                    state_nx = IDLE;
                else if (word_done)
                    state_nx = EMIT;
            end
            EMIT:    state_nx = bus.count_en ? ACCUM : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Divider, mic clock and synchronizer run regardless of count_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            bus.micClk <= 1'b0;
            sync1      <= 1'b0;
            mic_s      <= 1'b0;
        end else begin
            div_cnt    <= strb ? '0 : div_cnt + 1'b1;
            bus.micClk <= (div_cnt < DIV_W'(CLK_DIV / 2));
            sync1      <= bus.micData;
            mic_s      <= sync1;
        end
    end

    // A low count_en outranks a coincident strobe, discarding the partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win          <= '0;
            ones         <= '0;
            slot         <= '0;
            pack         <= '0;
            bus.ram_data <= '0;
        end else if (!bus.count_en) begin
            win  <= '0;
            ones <= '0;
            slot <= '0;
        end else if (strb) begin
            if (win_last) begin
                win  <= '0;
                ones <= '0;
                slot <= slot + 2'd1;
                if (slot == 2'd3)
                    bus.ram_data <= {sample, pack};
                else
                    pack[sample_w*int'(slot) +: sample_w] <= sample;
            end else begin
                win  <= win + 1'b1;
                ones <= ones_total;
            end
        end
    end
endmodule

// File: tb/tb_pdm_word_sampler.sv
// Self-checking bench for pdm_word_sampler: default-size word timing, saturation build check,
// and a reduced-size instance driven with random data against a per-strobe reference model.
module tb_pdm_word_sampler;
    localparam int D1 = 4;
    localparam int C1 = 20;

    logic clk, rst_n_a, rst_n_b;
    int   pass_cnt, check_cnt, fail_cnt;
    int   gcyc;

    pdm_word_sampler_if #(.sample_w(8)) if0 ();
    pdm_word_sampler_if #(.sample_w(8)) if1 ();
    pdm_word_sampler_if #(.sample_w(8)) if2 ();

    pdm_word_sampler t0 (.clk(clk), .rst_n(rst_n_a), .bus(if0));
    pdm_word_sampler #(.count_w(5), .clocks(C1), .sample_w(8), .CLK_DIV(D1))
        t1 (.clk(clk), .rst_n(rst_n_b), .bus(if1));
    pdm_word_sampler #(.count_w(9), .clocks(300), .sample_w(8), .CLK_DIV(4))
        t2 (.clk(clk), .rst_n(rst_n_a), .bus(if2));

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) gcyc <= 0;
        else          gcyc <= gcyc + 1;
    end

    int          wr0_n = 0, wr0_c1 = 0, wr0_c2 = 0;
    logic [31:0] wr0_d1 = '0;
    int          wr2_n = 0, wr2_c1 = 0;
    logic [31:0] wr2_d1 = '0;

    always @(negedge clk) begin
        if (rst_n_a && if0.ram_wr) begin
            if (wr0_n == 0) begin wr0_c1 = gcyc; wr0_d1 = if0.ram_data; end
            else if (wr0_n == 1) wr0_c2 = gcyc;
            wr0_n++;
        end
        if (rst_n_a && if2.ram_wr) begin
            if (wr2_n == 0) begin wr2_c1 = gcyc; wr2_d1 = if2.ram_data; end
            wr2_n++;
        end
    end

    // Reference model for t1: a list of counted bits per window and samples per word.
    int          e;
    logic        mic_hist[$];
    logic        win_bits[$];
    logic [7:0]  samples[$];
    logic        exp_wr, exp_clk;
    logic [31:0] exp_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] to_sample(input int n);
`ifdef PDM_SAT_EN
        return (n > 255) ? 8'hFF : 8'(n);
`else
        return 8'(n);
`endif
    endfunction

    task automatic model_reset();
        e = 0;
        mic_hist.delete();
        win_bits.delete();
        samples.delete();
        exp_wr   = 1'b0;
        exp_clk  = 1'b0;
        exp_data = '0;
    endtask

    // One clock of t1: drive at negedge, predict at the edge, compare at the next negedge.
    task automatic tick(input logic md, input logic en);
        int   ones;
        logic bitv;
        if1.micData  = md;
        if1.count_en = en;
        @(posedge clk);
        e++;
        mic_hist.push_back(md);
        bitv   = (e >= 3) ? mic_hist[e-3] : 1'b0;
        exp_wr = 1'b0;
        if (!en) begin
            win_bits.delete();
            samples.delete();
        end else if (e % D1 == 0) begin
            win_bits.push_back(bitv);
            if (win_bits.size() == C1) begin
                ones = 0;
                foreach (win_bits[i]) ones += int'(win_bits[i]);
                samples.push_back(to_sample(ones));
                win_bits.delete();
                if (samples.size() == 4) begin
                    exp_data = {samples[3], samples[2], samples[1], samples[0]};
                    exp_wr   = 1'b1;
                    samples.delete();
                end
            end
        end
        exp_clk = (((e - 1) % D1) < D1 / 2);
        @(negedge clk);
        check("ram_wr", 32'(if1.ram_wr), 32'(exp_wr));
        check("ram_data", if1.ram_data, exp_data);
        check("micClk", 32'(if1.micClk), 32'(exp_clk));
    endtask

    initial begin
        int pulses;
        pass_cnt = 0; check_cnt = 0; fail_cnt = 0;
        clk = 1'b0;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        if0.micData = 1'b1; if0.count_en = 1'b1;
        if2.micData = 1'b1; if2.count_en = 1'b1;
        if1.micData = 1'b0; if1.count_en = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_ram_wr", 32'(if1.ram_wr), 32'd0);
        check("rst_ram_data", if1.ram_data, 32'd0);
        check("rst_micClk", 32'(if1.micClk), 32'd0);
        check("rst_micClk_def", 32'(if0.micClk), 32'd0);
        check("rst_ram_data_def", if0.ram_data, 32'd0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Alternating synchronized data: half the window counts ones.
        for (int i = 0; i < 640; i++) tick(((i / D1) % 2) == 1, 1'b1);
        check("alt_word", if1.ram_data, 32'h0A0A0A0A);

        // Random data with occasional count_en drops.
        for (int i = 0; i < 1200; i++)
            tick(1'($urandom_range(0, 1)), $urandom_range(0, 299) != 0);

        // Single-cycle drop restarts a full word.
        tick(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 200; i++) tick(1'($urandom_range(0, 1)), 1'b1);
        tick(1'($urandom_range(0, 1)), 1'b0);
        pulses = 0;
        for (int i = 0; i < 316; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b1);
            if (if1.ram_wr) pulses++;
        end
        check("drop_no_early_wr", 32'(pulses), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b1);
            if (if1.ram_wr) pulses++;
        end
        check("drop_one_wr", 32'(pulses), 32'd1);

        // Controller-style gating: count_en low while ram_wr is high.
        tick(1'($urandom_range(0, 1)), 1'b0);
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1'($urandom_range(0, 1)), !if1.ram_wr);
            if (if1.ram_wr) pulses++;
        end
        check("gated_words", 32'(pulses), 32'd3);

        // Asynchronous reset mid-word.
        for (int i = 0; i < 100; i++) tick(1'($urandom_range(0, 1)), 1'b1);
        #2 rst_n_b = 1'b0;
        #1;
        check("async_rst_data", if1.ram_data, 32'd0);
        check("async_rst_wr", 32'(if1.ram_wr), 32'd0);
        check("async_rst_clk", 32'(if1.micClk), 32'd0);
        @(negedge clk);
        check("hold_rst_clk", 32'(if1.micClk), 32'd0);
        rst_n_b = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++) tick(1'($urandom_range(0, 1)), 1'b1);

        // Default-size and wide-window instances run alongside from the start.
        while (wr0_n < 2 && gcyc < 82000) @(negedge clk);
        check("def_wr_count", 32'(wr0_n >= 2), 32'd1);
        check("def_first_wr_cycle", 32'(wr0_c1), 32'd40320);
        check("def_first_word", wr0_d1, 32'hF0F0F0F0);
        check("def_word_period", 32'(wr0_c2 - wr0_c1), 32'd40320);
        check("wide_first_wr_cycle", 32'(wr2_c1), 32'd4800);
`ifdef PDM_SAT_EN
        check("wide_word", wr2_d1, 32'hFFFFFFFF);
`else
        check("wide_word", wr2_d1, 32'h2C2C2C2C);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
